// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pkg
//  Purpose  : Shared constants and the stage-1 register layout for the
//             single-precision multiplier normalize/round stage.
//  Contents : EXP_W, MAN_W, BIAS, QNAN, derived widths, s1_t struct.
//  Revision : 1.0  initial release
// ============================================================================
package fp_mul_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;

    // Exponent carried with two guard bits so it stays signed and never wraps.
    localparam int XEXP_W = EXP_W + 2;
    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int RES_W  = EXP_W + MAN_W + 1;

    localparam logic [RES_W-1:0]  QNAN    = 32'h7FC0_0000;
    localparam logic [XEXP_W-1:0] EXP_ONE = XEXP_W'(1);
    // Smallest exponent that no longer fits a finite result.
    localparam logic [XEXP_W-1:0] EXP_SAT = XEXP_W'(2 * BIAS + 1);

    typedef struct packed {
        logic              sign;
        logic [XEXP_W-1:0] exp;    // two's complement
        logic [MAN_W-1:0]  frac;
        logic              g;
        logic              r;
        logic              s;
        logic              zero;
        logic              inf;
        logic              nan;
    } s1_t;

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
//  Module   : fp_round_rne
//  Purpose  : Combinational round-to-nearest-even of a normalized fraction.
//  Ports    : i_frac/i_g/i_r/i_s - fraction with guard, round, sticky bits
//             i_exp              - signed extended exponent
//             o_frac/o_exp       - rounded fraction and adjusted exponent
//  Revision : 1.0  initial release
// ============================================================================
module fp_round_rne
    import fp_mul_pkg::*;
(
    input  logic [MAN_W-1:0]  i_frac,
    input  logic              i_g,
    input  logic              i_r,
    input  logic              i_s,
    input  logic [XEXP_W-1:0] i_exp,
    output logic [MAN_W-1:0]  o_frac,
    output logic [XEXP_W-1:0] o_exp
);

    logic         w_round_up;
    logic [MAN_W:0] w_sum;

    // Ties (G=1, R=S=0) go up only when the fraction is odd.
    assign w_round_up = i_g & (i_r | i_s | i_frac[0]);
    assign w_sum      = {1'b0, i_frac} + {{MAN_W{1'b0}}, w_round_up};

    // Carry out of the fraction means the significand became 2.0: renormalize.
    assign o_frac = w_sum[MAN_W] ? '0 : w_sum[MAN_W-1:0];
    assign o_exp  = w_sum[MAN_W] ? (i_exp + EXP_ONE) : i_exp;

endmodule
`default_nettype wire

// File: rtl/fp_mul_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_norm_round
//  Purpose  : Final multiplier stage: normalize the 48-bit mantissa product,
//             round to nearest-even, flag overflow/underflow, pack IEEE-754.
//             Two-stage pipeline with valid/ready on both sides.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready, in_sign, in_exp, in_mant, in_zero/inf/nan
//             out_valid/out_ready, out_result, out_ovf, out_unf
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_norm_round
    import fp_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [XEXP_W-1:0] in_exp,
    input  logic [PROD_W-1:0] in_mant,
    input  logic              in_zero,
    input  logic              in_inf,
    input  logic              in_nan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic              out_ovf,
    output logic              out_unf
);

    s1_t               r_s1;
    logic              r_s1_valid;
    logic              r_out_valid;
    logic [RES_W-1:0]  r_out_result;
    logic              r_out_ovf;
    logic              r_out_unf;

    s1_t               w_s1_d;
    logic              w_s2_ready;
    logic [MAN_W-1:0]  w_rnd_frac;
    logic [XEXP_W-1:0] w_rnd_exp;
    logic [RES_W-1:0]  w_res;
    logic              w_ovf;
    logic              w_unf;

    assign w_s2_ready = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;

    // ---------------- stage 1: normalize ----------------
    // The product of two [1,2) significands lies in [1,4); bit 47 set means
    // the value is >= 2 and needs one extra right shift.
    always_comb begin
        w_s1_d      = '0;
        w_s1_d.sign = in_sign;
        w_s1_d.zero = in_zero;
        w_s1_d.inf  = in_inf;
        w_s1_d.nan  = in_nan;
        if (in_mant[PROD_W-1]) begin
            w_s1_d.frac = in_mant[PROD_W-2 -: MAN_W];
            w_s1_d.g    = in_mant[PROD_W-2-MAN_W];
            w_s1_d.r    = in_mant[PROD_W-3-MAN_W];
            w_s1_d.s    = |in_mant[PROD_W-4-MAN_W:0];
            w_s1_d.exp  = in_exp + EXP_ONE;
        end else begin
            w_s1_d.frac = in_mant[PROD_W-3 -: MAN_W];
            w_s1_d.g    = in_mant[PROD_W-3-MAN_W];
            w_s1_d.r    = in_mant[PROD_W-4-MAN_W];
            w_s1_d.s    = |in_mant[PROD_W-5-MAN_W:0];
            w_s1_d.exp  = in_exp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1 <= w_s1_d;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    fp_round_rne u_round (
        .i_frac (r_s1.frac),
        .i_g    (r_s1.g),
        .i_r    (r_s1.r),
        .i_s    (r_s1.s),
        .i_exp  (r_s1.exp),
        .o_frac (w_rnd_frac),
        .o_exp  (w_rnd_exp)
    );

    always_comb begin
        w_res = {r_s1.sign, w_rnd_exp[EXP_W-1:0], w_rnd_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_s1.nan) begin
            w_res = QNAN;
        end else if (r_s1.inf) begin
            w_res = {r_s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_s1.zero) begin
            w_res = {r_s1.sign, {(EXP_W+MAN_W){1'b0}}};
        end else if ($signed(w_rnd_exp) >= $signed(EXP_SAT)) begin
            w_res = {r_s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
        end else if ($signed(w_rnd_exp) < $signed(EXP_ONE)) begin
            // No subnormal support: anything below the normal range flushes.
            w_res = {r_s1.sign, {(EXP_W+MAN_W){1'b0}}};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_ovf    <= 1'b0;
            r_out_unf    <= 1'b0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= w_res;
                r_out_ovf    <= w_ovf;
                r_out_unf    <= w_unf;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_ovf    = r_out_ovf;
    assign out_unf    = r_out_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_norm_round
//  Purpose  : Self-checking bench for fp_mul_norm_round: directed vector
//             table, backpressure/throughput/reset sequences and random
//             traffic scored against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_zero;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;

    fp_mul_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .in_nan     (in_nan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        zero;
        logic        inf;
        logic        nan;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    logic [33:0] sb_q[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out;
    logic        saw_in_ready_low;
    logic        last_xfer;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: treat the product as an integer, pick the shift that leaves a
    // 24-bit significand, and round on the numeric value of the remainder.
    function automatic logic [33:0] model(input logic s, input logic [9:0] e,
                                          input logic [47:0] m, input logic z,
                                          input logic inf, input logic nan);
        longint ee, mm, q, rem, half;
        int     sh;
        if (nan) return {32'h7FC0_0000, 2'b00};
        if (inf) return {s, 8'hFF, 23'd0, 2'b00};
        if (z)   return {s, 31'd0, 2'b00};
        ee = longint'($signed(e));
        mm = longint'(m);
        sh = (mm >= (longint'(1) << 47)) ? 24 : 23;
        if (sh == 24) ee = ee + 1;
        q    = mm >> sh;
        rem  = mm - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q >= (longint'(1) << 24)) begin
            q  = q >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) return {s, 8'hFF, 23'd0, 2'b10};
        if (ee <= 0)   return {s, 31'd0, 2'b01};
        return {s, 8'(ee), 23'(q), 2'b00};
    endfunction

    // Runs at the falling edge: stall stability, output scoring, input capture.
    task automatic monitor();
        logic [33:0] exp_v;
        last_xfer = 1'b0;
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("stall_valid_hold", 64'(out_valid), 64'd1);
            chk("stall_data_hold", 64'({out_result, out_ovf, out_unf}), 64'(prev_out));
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'(out_result), 64'hDEAD_BEEF);
            end else begin
                exp_v = sb_q.pop_front();
                chk("sb_result", 64'({out_result, out_ovf, out_unf}), 64'(exp_v));
            end
        end
        if (in_valid && in_ready) begin
            last_xfer = 1'b1;
            sb_q.push_back(model(in_sign, in_exp, in_mant, in_zero, in_inf, in_nan));
        end
        if (!in_ready) saw_in_ready_low = 1'b1;
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_result, out_ovf, out_unf};
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m,
                         input logic z, input logic inf, input logic nan);
        in_sign = s; in_exp = e; in_mant = m;
        in_zero = z; in_inf = inf; in_nan = nan;
    endtask

    function automatic vec_t mk(input string nm, input logic s, input logic [9:0] e,
                                input logic [47:0] m, input logic z, input logic inf,
                                input logic nan, input logic [31:0] r,
                                input logic ovf, input logic unf);
        vec_t v;
        v.name = nm; v.sign = s; v.exp = e; v.mant = m;
        v.zero = z; v.inf = inf; v.nan = nan;
        v.res = r; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        drive(v.sign, v.exp, v.mant, v.zero, v.inf, v.nan);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({v.name, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        chk({v.name, "_lat2"}, 64'(out_valid), 64'd1);
        chk(v.name, 64'({out_result, out_ovf, out_unf}), 64'({v.res, v.ovf, v.unf}));
    endtask

    task automatic rand_beat();
        logic [63:0] r64;
        logic [47:0] m;
        logic [9:0]  e;
        int          v;
        r64 = {$urandom, $urandom};
        m   = r64[47:0];
        if ($urandom_range(0, 1) == 1) m[47] = 1'b1;
        else m[47:46] = 2'b01;
        if ($urandom_range(0, 3) == 0) m[20:0] = '0;
        case ($urandom_range(0, 2))
            0:       v = int'($urandom_range(240, 262));
            1:       v = int'($urandom_range(0, 16)) - 10;
            default: v = int'($urandom_range(1, 254));
        endcase
        e = v[9:0];
        drive($urandom_range(0, 1) == 1, e, m,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0);
    endtask

    vec_t vt[$];

    initial begin
        int sent;
        int cyc;
        int out0;
        logic [0:9] pat;

        vt.push_back(mk("mul_1p5x1p5",   0, 10'd127, 48'h9000_0000_0000, 0,0,0, 32'h4010_0000, 0,0));
        vt.push_back(mk("tie_odd_up",    0, 10'd127, 48'h4000_00C0_0000, 0,0,0, 32'h3F80_0002, 0,0));
        vt.push_back(mk("tie_even_keep", 0, 10'd127, 48'h4000_0040_0000, 0,0,0, 32'h3F80_0000, 0,0));
        vt.push_back(mk("round_carry",   0, 10'd127, 48'h7FFF_FFC0_0001, 0,0,0, 32'h4000_0000, 0,0));
        vt.push_back(mk("overflow",      0, 10'd254, 48'h8000_0000_0000, 0,0,0, 32'h7F80_0000, 1,0));
        vt.push_back(mk("round_ovf",     1, 10'd254, 48'h7FFF_FFC0_0001, 0,0,0, 32'hFF80_0000, 1,0));
        vt.push_back(mk("max_normal",    0, 10'd254, 48'h4000_0000_0000, 0,0,0, 32'h7F00_0000, 0,0));
        vt.push_back(mk("min_normal",    0, 10'd1,   48'h4000_0000_0000, 0,0,0, 32'h0080_0000, 0,0));
        vt.push_back(mk("unf_exp0",      1, 10'd0,   48'h4000_0000_0000, 0,0,0, 32'h8000_0000, 0,1));
        vt.push_back(mk("unf_neg5",      0, 10'h3FB, 48'h4000_0000_0000, 0,0,0, 32'h0000_0000, 0,1));
        vt.push_back(mk("unf_neg1_norm", 0, 10'h3FF, 48'h8000_0000_0000, 0,0,0, 32'h0000_0000, 0,1));
        vt.push_back(mk("nan",           1, 10'd127, 48'h9000_0000_0000, 0,0,1, 32'h7FC0_0000, 0,0));
        vt.push_back(mk("nan_priority",  1, 10'd300, 48'h8000_0000_0000, 1,1,1, 32'h7FC0_0000, 0,0));
        vt.push_back(mk("inf_neg",       1, 10'd127, 48'h9000_0000_0000, 0,1,0, 32'hFF80_0000, 0,0));
        vt.push_back(mk("zero_neg",      1, 10'd127, 48'h9000_0000_0000, 1,0,0, 32'h8000_0000, 0,0));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        saw_in_ready_low = 1'b0;
        drive(0, '0, '0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags",  64'({out_ovf, out_unf}), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        foreach (vt[i]) apply_vec(vt[i]);
        tick();

        // Full throughput: with out_ready high, five beats take five cycles.
        sent = 0; cyc = 0;
        in_valid = 1'b1;
        while (sent < 5 && cyc < 20) begin
            rand_beat();
            tick();
            cyc++;
            if (last_xfer) sent++;
        end
        in_valid = 1'b0;
        chk("throughput_cycles", 64'(cyc), 64'd5);
        repeat (3) tick();

        // Backpressure: four beats, downstream stalls two cycles.
        pat = 10'b1100111111;
        sent = 0; out0 = n_out; saw_in_ready_low = 1'b0;
        for (int c = 0; c < 10; c++) begin
            out_ready = pat[c];
            in_valid  = (sent < 4);
            if (in_valid) drive(0, 10'd127, 48'h8000_0000_0000 | 48'(sent << 24), 0, 0, 0);
            tick();
            if (last_xfer) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("bp_in_ready_dropped", 64'(saw_in_ready_low), 64'd1);
        chk("bp_beats_sent", 64'(sent), 64'd4);
        chk("bp_beats_out", 64'(n_out - out0), 64'd4);
        chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
        tick();
        drive(1, 10'd130, 48'hC000_0000_0000, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result",    64'(out_result), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        out0 = n_out;
        repeat (5) tick();
        chk("post_rst_no_stale", 64'(n_out - out0), 64'd0);
        chk("post_rst_valid",    64'(out_valid), 64'd0);

        // Random traffic with random backpressure.
        sent = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && sent < 300; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                rand_beat();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_xfer) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rand_beats_sent", 64'(sent), 64'd300);
        chk("rand_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
- Final stage of the single-precision floating-point multiplier datapath.
- Consumes three inputs from the upstream stages:
  - the sign;
  - the biased result exponent from the exponent-subtract stage, sign-extended with its carry;
  - the 48-bit mantissa product.
- Normalizes, rounds to nearest-even, detects overflow/underflow and packs an IEEE-754 single result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width
BIAS, 127, exponent bias (used only for the saturation limit 2*BIAS+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept a beat
in_sign  input  1  result sign (XOR of operand signs)
in_exp  input  EXP_W+2  biased exponent, two's complement signed, after bias subtraction
in_mant  input  2*(MAN_W+1)  unsigned mantissa product, hidden bits included
in_zero  input  1  either operand zero
in_inf  input  1  either operand infinity, neither NaN
in_nan  input  1  either operand NaN, or inf*0
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  EXP_W+MAN_W+1  packed {sign, exp, frac}
out_ovf  output  1  result overflowed to infinity
out_unf  output  1  result underflowed, flushed to zero

Behaviour:
- Reset values: all pipeline valid bits 0, out_valid=0, out_result=0, out_ovf=0, out_unf=0. in_ready reads 1 once reset is deasserted.
- Reset asserted mid-operation discards all in-flight beats immediately; no partial output appears.
- Handshake:
  - A beat transfers when valid && ready.
  - in_ready = !s1_valid || s2_ready.
  - s2_ready = !out_valid || out_ready.
  - Full throughput: 1 beat/cycle when out_ready is held high.
  - Latency: 2 cycles from input transfer to out_valid.
  - While out_valid=1 && out_ready=0, out_result/out_ovf/out_unf stay stable and upstream stalls.
- Stage 1 (normalize), captured on input transfer:
  - If in_mant[47]=1: fraction = in_mant[46:24], G = in_mant[23], R = in_mant[22], S = OR(in_mant[21:0]), exp = in_exp+1.
  - Else: fraction = in_mant[45:23], G = in_mant[22], R = in_mant[21], S = OR(in_mant[20:0]), exp = in_exp.
  - Special flags and sign pass through.
- Stage 2 (round/pack):
  - Round up iff G && (R || S || frac[0]).
  - Rounded fraction is computed 24 bits wide. On carry-out, fraction becomes 0 and exp increments by 1.
  - Priority, highest first:
    1. nan → 0x7FC00000, sign forced 0.
    2. inf → {sign, 0xFF, 0}.
    3. zero → {sign, 0, 0}.
    4. exp >= 255 → {sign, 0xFF, 0}, out_ovf=1.
    5. exp <= 0 (signed) → {sign, 0, 0}, out_unf=1. No subnormals.
    6. Otherwise normal pack.
  - out_ovf and out_unf are 0 for special-input cases.
- Widths: all exponent arithmetic is done in EXP_W+2 bits signed, so there is no wrap-around; negative values never alias to large positives.

Decomposition:
- Package fp_mul_pkg holds:
  - constants EXP_W, MAN_W, BIAS, QNAN (32'h7FC00000);
  - a packed struct for the stage-1 register (sign, exp, frac, g, r, s, zero, inf, nan).
- Natural sub-module: fp_round_rne. Combinational, takes frac, g, r, s, exp and returns the rounded frac and adjusted exp. It is instantiated once in stage 2.

Test Plan:
- 1.5*1.5 (in_exp=127, in_mant=0x900000<<24) → 2.25 = 0x40100000, out_valid 2 cycles after transfer.
- Tie round-to-even: in_mant[47]=0, frac lsb=1, G=1, R=S=0, in_exp=127 → frac+1. With frac lsb=0 → frac unchanged.
- Round carry-out: frac all 1s, G=1, S=1, in_exp=127 → 0x40000000 (exp 128, frac 0).
- Overflow: in_exp=254, in_mant[47]=1 → 0x7F800000, out_ovf=1.
- Underflow: in_exp=0 (or -5), in_mant[46]=1 → 0x00000000 with sign, out_unf=1.
- Specials: nan → 0x7FC00000; inf with sign=1 → 0xFF800000.
- Backpressure: stream 4 beats with out_ready toggling 1,0,0,1 → in_ready drops when both stages are full, results arrive in order with no loss or duplication, out_result holds during stall.
- Assert rst with 2 beats in flight → out_valid=0 that cycle, no stale result after release.
